fmult_normalize: RTL
====================

// Module: fmult_normalize
// PURPOSE
//  Downstream stage of the single-precision multiplier datapath.
//  - Consumes: raw 48-bit significand product (hidden bits included), biased exponent sum, sign, special-case flags.
//  - Produces: normalized, rounded, packed IEEE-754 result plus status flags.
//  - Two-stage pipeline with valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8   exponent field width; internal signed exponent is EXP_W+2 bits
//  FRAC_W  23  fraction field width; product width PW = 2*(FRAC_W+1) = 48
// PORTS
//  clk           in   1        single clock; all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        upstream holds a valid product
//  in_ready      out  1        stage accepts this cycle
//  in_sign       in   1        sign_a ^ sign_b
//  in_exp_sum    in   10       signed two's-complement ea+eb-127
//  in_mant_prod  in   48       {1,frac_a} * {1,frac_b}
//  in_is_nan     in   1        either operand NaN, or inf*zero
//  in_is_inf     in   1        either operand infinite (and not NaN case)
//  in_is_zero    in   1        either operand zero/subnormal (and not NaN case)
//  out_valid     out  1        result valid
//  out_ready     in   1        downstream accepts
//  out_result    out  32       {sign, exp[7:0], frac[22:0]}
//  out_overflow  out  1        finite result rounded to infinity
//  out_underflow out  1        result flushed to zero
//  out_inexact   out  1        guard|sticky nonzero, or overflow/underflow
// BEHAVIOUR
//  Reset: all outputs, both stage valids and payloads go to 0. in_ready=1 the cycle after reset.
//  Reset mid-operation: in-flight items are discarded; no output is produced for them.
//  Handshake: transfer when valid&ready on a side.
//  - Stage advances when its successor is empty or advancing.
//  - in_ready = !s1_valid | (!s2_valid | out_ready).
//  - Output payload is held stable while out_valid & !out_ready.
//  - Full throughput: one result/cycle; latency 2 cycles, accept edge to out_valid.
//  Stage 1, normalize:
//  - prod[47]=1: frac=prod[46:24], g=prod[23], s=|prod[22:0], e=exp_sum+1.
//  - Otherwise: frac=prod[45:23], g=prod[22], s=|prod[21:0], e=exp_sum.
//  Stage 2, round + pack:
//  - Rounding per CONFIGURATION.
//  - Carry out of frac+1 sets frac=0, e=e+1.
//  - e>=255 after rounding: out=sign|0x7F800000, overflow=1, inexact=1.
//  - e<=0: out=sign|0x00000000, underflow=1, inexact=1. Subnormal outputs are not produced.
//  - Otherwise: out={sign, e[7:0], frac}, inexact=g|s.
//  Special-case priority: nan > inf > zero > normal.
//  - nan: 0x7FC00000, flags 0.
//  - inf: sign|0x7F800000, flags 0.
//  - zero: sign|0, flags 0.
// CONFIGURATION
//  FMULT_ROUND_NEAREST_EN defined: round-to-nearest-even.
//  - Increment when g & (s | frac[0]).
//  FMULT_ROUND_NEAREST_EN undefined: truncate toward zero.
//  - No increment and no rounding carry; inexact still reported.
// STRUCTURE
//  Package fmult_pkg, shared with the multiplier stage:
//  - BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, INF_MAG=31'h7F800000.
//  - Typedef of the stage-1 payload: sign, e, frac, g, s, nan, inf, zero.
//  Sub-module fmult_round: combinational rounding, overflow/underflow, packing; instantiated in stage 2.
// TESTING
//  1. prod=48'h6000_0000_0000, exp_sum=128, sign=0 -> out 0x40400000 (1.5*2.0), flags 0, 2 cycles after accept.
//  2. prod=48'h9000_0000_0000, exp_sum=127 -> 0x40100000 (1.5*1.5).
//  3. prod=48'h7FFF_FFC0_0000, exp_sum=127:
//     - RNE: 0x40000000, inexact=1.
//     - Macro off: 0x3FFFFFFF, inexact=1.
//  4. Range limits:
//     - prod bit47 set, exp_sum=254 -> 0x7F800000, overflow=1.
//     - exp_sum=-10, sign=1 -> 0x80000000, underflow=1.
//  5. Specials: in_is_nan with in_is_inf -> 0x7FC00000; in_is_zero, sign=1 -> 0x80000000.
//  6. Backpressure and reset:
//     - Stream 4 items, out_ready low 3 cycles: out_result stable, in_ready drops, all 4 results in order, no loss/dup.
//     - rst pulse mid-stream: out_valid=0 next cycle.

Source files
------------

// File: rtl/fmult_pkg.sv
// Shared constants and payload types for the single-precision multiplier datapath.
// The field widths live here so the multiplier and normalize stages agree on one layout.
package fmult_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int PW      = 2 * (FRAC_W + 1);
    localparam int EW      = EXP_W + 2;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    // Normalized but unrounded product, carried between the two pipeline stages.
    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] e;
        logic [FRAC_W-1:0]    frac;
        logic                 g;
        logic                 s;
        logic                 nan;
        logic                 inf;
        logic                 zero;
    } s1_t;

    typedef struct packed {
        logic [31:0] result;
        logic        overflow;
        logic        underflow;
        logic        inexact;
    } res_t;

endpackage

// File: rtl/fmult_normalize_if.sv
// Upstream product handshake and downstream packed-result handshake of the normalize stage.
// master drives products and accepts results; slave is the normalize stage itself.
interface fmult_normalize_if;
    import fmult_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [EW-1:0] in_exp_sum;
    logic [PW-1:0]        in_mant_prod;
    logic                 in_is_nan;
    logic                 in_is_inf;
    logic                 in_is_zero;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic                 out_overflow;
    logic                 out_underflow;
    logic                 out_inexact;

    modport master (
        output in_valid, in_sign, in_exp_sum, in_mant_prod, in_is_nan, in_is_inf, in_is_zero,
        input  in_ready,
        input  out_valid, out_result, out_overflow, out_underflow, out_inexact,
        output out_ready
    );

    modport slave (
        input  in_valid, in_sign, in_exp_sum, in_mant_prod, in_is_nan, in_is_inf, in_is_zero,
        output in_ready,
        output out_valid, out_result, out_overflow, out_underflow, out_inexact,
        input  out_ready
    );

endinterface

// File: rtl/fmult_round.sv
// Purpose: round, range-check and pack a normalized product into IEEE-754 single (FMULT_ROUND_NEAREST_EN = RNE, else truncate).
// Latency: combinational.
// Backpressure: none; the enclosing stage register holds the result.
module fmult_round
    import fmult_pkg::*;
(
    input  s1_t  din,
    output res_t dout
);

    localparam logic signed [EW-1:0] E_MAX = EW'(EXP_MAX);

    logic                 round_up;
    logic [FRAC_W:0]      sum;
    logic signed [EW-1:0] e_r;

`ifdef FMULT_ROUND_NEAREST_EN
    assign round_up = din.g & (din.s | din.frac[0]);
`else
    assign round_up = 1'b0;
`endif

    // A carry out of the fraction wraps it to zero and bumps the exponent.
    assign sum = {1'b0, din.frac} + {{FRAC_W{1'b0}}, round_up};
    assign e_r = din.e + {{(EW-1){1'b0}}, sum[FRAC_W]};

    always_comb begin
        dout = '0;
        if (din.nan) begin
            dout.result = QNAN;
        end else if (din.inf) begin
            dout.result = {din.sign, INF_MAG};
        end else if (din.zero) begin
            dout.result = {din.sign, 31'd0};
        end else if (e_r >= E_MAX) begin
            dout.result    = {din.sign, INF_MAG};
            dout.overflow  = 1'b1;
            dout.inexact   = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            // Subnormals are not produced; anything below the normal range flushes to zero.
            dout.result    = {din.sign, 31'd0};
            dout.underflow = 1'b1;
            dout.inexact   = 1'b1;
        end else begin
            dout.result  = {din.sign, e_r[EXP_W-1:0], sum[FRAC_W-1:0]};
            dout.inexact = din.g | din.s;
        end
    end

endmodule

// File: rtl/fmult_normalize.sv
// Purpose: normalize a 48-bit significand product, then round/pack it (rounding mode via FMULT_ROUND_NEAREST_EN).
// Latency: 2 cycles from accept to out_valid, one result per cycle.
// Backpressure: each stage advances only when its successor is empty or draining; output held while stalled.
module fmult_normalize
    import fmult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fmult_normalize_if.slave io
);

    logic s1_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    res_t res_d;
    logic s2_adv;

    assign s2_adv      = !io.out_valid | io.out_ready;
    assign io.in_ready = !s1_valid | s2_adv;

    // Product of two 1.x significands lies in [1,4): bit PW-1 picks the one-bit right shift.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = io.in_sign;
        s1_d.nan  = io.in_is_nan;
        s1_d.inf  = io.in_is_inf;
        s1_d.zero = io.in_is_zero;
        if (io.in_mant_prod[PW-1]) begin
            s1_d.frac = io.in_mant_prod[PW-2 -: FRAC_W];
            s1_d.g    = io.in_mant_prod[PW-FRAC_W-2];
            s1_d.s    = |io.in_mant_prod[PW-FRAC_W-3:0];
            s1_d.e    = io.in_exp_sum + EW'(1);
        end else begin
            s1_d.frac = io.in_mant_prod[PW-3 -: FRAC_W];
            s1_d.g    = io.in_mant_prod[PW-FRAC_W-3];
            s1_d.s    = |io.in_mant_prod[PW-FRAC_W-4:0];
            s1_d.e    = io.in_exp_sum;
        end
    end

    fmult_round u_round (
        .din  (s1_q),
        .dout (res_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_q             <= '0;
            io.out_valid     <= 1'b0;
            io.out_result    <= '0;
            io.out_overflow  <= 1'b0;
            io.out_underflow <= 1'b0;
            io.out_inexact   <= 1'b0;
        end else begin
            if (io.in_ready) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                io.out_valid <= s1_valid;
                if (s1_valid) begin
                    io.out_result    <= res_d.result;
                    io.out_overflow  <= res_d.overflow;
                    io.out_underflow <= res_d.underflow;
                    io.out_inexact   <= res_d.inexact;
                end
            end
        end
    end

endmodule
